// File: rtl/ram_init_pkg.sv
// Shared types for the RAM fill engine.
//   fill_state_t    : controller states
//   MODE_CONST_BIT  : mode bit selecting constant fill (else identity S[i]=i)
//   MODE_VERIFY_BIT : mode bit requesting a read-back verify pass after the fill
package ram_init_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        VERIFY,
        DRAIN,
        DONE
    } fill_state_t;

    localparam int MODE_CONST_BIT  = 0;
    localparam int MODE_VERIFY_BIT = 1;

endpackage

// File: rtl/ram_fill_delay.sv
// Fixed-latency shift register carrying a word plus its valid bit.
// Used to align the expected data/address of each verify read with the
// RAM read data, which arrives DEPTH cycles after the address.
//   clk, reset : clock, synchronous active-high reset (valid bits only)
//   in_vld     : valid for in_data this cycle
//   in_data    : WIDTH-bit payload
//   out_vld    : in_vld delayed by DEPTH cycles
//   out_data   : in_data delayed by DEPTH cycles
module ram_fill_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Payload carries no reset: it is qualified by the valid bit.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/ram_fill_engine.sv
// RAM fill engine: writes DEPTH words with an identity pattern (S[i]=i) or a
// constant, then optionally reads the RAM back and checks every word.
//   clk, reset   : clock, synchronous active-high reset
//   start        : begin a run (accepted only in IDLE/DONE)
//   mode         : [0] 1=constant fill, [1] 1=verify pass after fill
//   fill_value   : constant used when mode[0]=1
//   wr_en/wr_addr/wr_data : RAM write port
//   rd_addr/rd_data       : RAM read port, data RD_LATENCY cycles after address
//   busy         : high in FILL/VERIFY/DRAIN
//   done         : level, high from completion until next accepted start
//   verify_error : sticky mismatch flag, cleared on accepted start
//   error_addr   : address of the first mismatch of the run, 0 if none
module ram_fill_engine
    import ram_init_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              verify_error,
    output logic [ADDR_W-1:0] error_addr
);

    localparam int DCNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam int DL_W   = DATA_W + ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [DCNT_W-1:0] LAST_DRAIN = DCNT_W'(RD_LATENCY - 1);

    // Identity word: address zero-extended or truncated to the word width.
    function automatic logic [DATA_W-1:0] identity_word(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    fill_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              accept;
    logic [1:0]        mode_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] exp_word;
    logic              rd_issue;
    logic              dl_vld;
    logic [DL_W-1:0]   dl_word;
    logic [DATA_W-1:0] dl_exp;
    logic [ADDR_W-1:0] dl_addr;

    // Next-state logic. Terminal test is cnt==DEPTH-1 so a full power-of-two
    // address space never needs a counter wider than ADDR_W.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = mode_q[MODE_VERIFY_BIT] ? VERIFY : DONE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            VERIFY: begin
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                // Last read still in flight; hold until its compare has landed.
                if (dcnt_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Run configuration is captured only when a start is accepted, so
    // input changes during a run have no effect.
    always_ff @(posedge clk) begin
        if (accept) begin
            mode_q <= mode;
            fill_q <= fill_value;
        end
    end

    assign exp_word = mode_q[MODE_CONST_BIT] ? fill_q : identity_word(cnt_q);
    assign rd_issue = (state_q == VERIFY);

    // Stage boundary: expected word and address ride alongside the RAM read.
    ram_fill_delay #(
        .WIDTH(DL_W),
        .DEPTH(RD_LATENCY)
    ) u_delay (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (rd_issue),
        .in_data ({exp_word, cnt_q}),
        .out_vld (dl_vld),
        .out_data(dl_word)
    );

    assign dl_exp  = dl_word[DL_W-1:ADDR_W];
    assign dl_addr = dl_word[ADDR_W-1:0];

    // First mismatch wins; later mismatches only keep the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            verify_error <= 1'b0;
            error_addr   <= '0;
        end else if (accept) begin
            verify_error <= 1'b0;
            error_addr   <= '0;
        end else if (dl_vld && (rd_data != dl_exp)) begin
            verify_error <= 1'b1;
            if (!verify_error) begin
                error_addr <= dl_addr;
            end
        end
    end

    assign wr_en   = (state_q == FILL);
    assign wr_addr = wr_en ? cnt_q : '0;
    assign wr_data = wr_en ? exp_word : '0;
    assign rd_addr = rd_issue ? cnt_q : '0;
    assign busy    = (state_q == FILL) || (state_q == VERIFY) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

endmodule
